mem_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined RV32I core. It shares one physical memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage, fed by the EX/MEM register's `mem_read`/`mem_write`). It latches the winning request, owns the downstream port until `mem_resp`, and routes the response back to the owner. Requesters stall their pipeline stage on their own request until their response pulse.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared enums and constants for the pipelined RV32I core.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int MASK_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between IF and MEM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [MASK_WIDTH-1:0] d_wmask,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
    logic                  is_write;
  } req_t;

  arb_state_t r_state;
  arb_state_t w_next;
  req_t       r_req;
  logic       r_last_d;
  logic       r_i_done;
  logic       r_d_done;
  logic       w_i_pend;
  logic       w_d_pend;
  logic       w_grant_i;
  logic       w_grant_d;

  // Done bits hide a request still held during its own response cycle.
  assign w_i_pend  = i_read && !r_i_done;
  assign w_d_pend  = (d_read || d_write) && !r_d_done;
  assign w_grant_i = (r_state == IDLE) && w_i_pend && (!w_d_pend || r_last_d);
  assign w_grant_d = (r_state == IDLE) && w_d_pend && !w_grant_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_next = I_BUSY;
        end else if (w_grant_d) begin
          w_next = D_BUSY;
        end
      end
      I_BUSY:  if (mem_resp) w_next = IDLE;
      D_BUSY:  if (mem_resp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req    <= '0;
      r_last_d <= 1'b1;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      r_i_done <= (r_state == I_BUSY) && mem_resp;
      r_d_done <= (r_state == D_BUSY) && mem_resp;
      if (w_grant_i) begin
        r_req.addr     <= i_addr;
        r_req.wdata    <= '0;
        r_req.wmask    <= '0;
        r_req.is_write <= 1'b0;
        r_last_d       <= 1'b0;
      end else if (w_grant_d) begin
        r_req.addr     <= d_addr;
        r_req.wdata    <= d_wdata;
        r_req.wmask    <= d_wmask;
        r_req.is_write <= d_write;
        r_last_d       <= 1'b1;
      end
    end
  end

  // Gating by rst drops the strobe in the very cycle reset is applied.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    i_resp    = 1'b0;
    i_rdata   = '0;
    d_resp    = 1'b0;
    d_rdata   = '0;
    if (rst) begin
      case (r_state)
        I_BUSY: begin
          mem_read = 1'b1;
          mem_addr = r_req.addr;
          if (mem_resp) begin
            i_resp  = 1'b1;
            i_rdata = mem_rdata;
          end
        end
        D_BUSY: begin
          mem_read  = !r_req.is_write;
          mem_write = r_req.is_write;
          mem_addr  = r_req.addr;
          mem_wdata = r_req.wdata;
          mem_wmask = r_req.wmask;
          if (mem_resp) begin
            d_resp  = 1'b1;
            d_rdata = mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ERR_RW: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int errors = 0;
  int strobes;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; d_wmask = 0; mem_rdata = 0; mem_resp = 0;
    tick(); tick();
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resps", {30'd0, i_resp, d_resp}, 32'd0);
    rst = 1'b1;

    // I-only read, memory answers on the third strobe cycle
    i_read = 1; i_addr = 32'h60;
    strobes = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (mem_read && mem_addr == 32'h60) strobes++;
      if (k < 2) tick();
    end
    chk("i_strobe_cycles", strobes, 32'd3);
    chk("i_wmask", {28'd0, mem_wmask}, 32'd0);
    mem_resp = 1; mem_rdata = 32'h13; #1;
    chk("i_resp", {31'd0, i_resp}, 32'd1);
    chk("i_rdata", i_rdata, 32'h13);
    chk("i_only_d_resp", {31'd0, d_resp}, 32'd0);
    tick();
    mem_resp = 0; i_read = 0; #1;
    chk("i_after_resp", {30'd0, mem_read, i_resp}, 32'd0);
    chk("i_rdata_gated", i_rdata, 32'd0);
    tick();

    // Held request: i_read stays high one cycle past i_resp
    i_read = 1; i_addr = 32'h200;
    tick();
    chk("held_strobe", {31'd0, mem_read}, 32'd1);
    mem_resp = 1; mem_rdata = 32'h55; #1;
    chk("held_resp", {31'd0, i_resp}, 32'd1);
    tick();
    mem_resp = 0; #1;
    chk("held_no_dup", {31'd0, mem_read}, 32'd0);
    i_read = 0;
    tick();
    chk("held_idle", {31'd0, mem_read}, 32'd0);
    i_read = 1;
    tick();
    chk("fresh_strobe", {31'd0, mem_read}, 32'd1);
    mem_resp = 1; #1;
    tick();
    mem_resp = 0; i_read = 0;
    tick();

    // Conflict round-robin from a fresh reset
    rst = 0; tick(); rst = 1;
    i_read = 1; i_addr = 32'h60; d_read = 1; d_addr = 32'h100;
    tick();
    chk("rr1_addr", mem_addr, 32'h60);
    mem_resp = 1; mem_rdata = 32'hAAA; #1;
    chk("rr1_resp", {30'd0, i_resp, d_resp}, 32'b10);
    tick();
    mem_resp = 0; #1;
    chk("rr1_idle", {31'd0, mem_read}, 32'd0);
    tick();
    chk("rr2_addr", mem_addr, 32'h100);
    chk("rr2_type", {30'd0, mem_read, mem_write}, 32'b10);
    mem_resp = 1; mem_rdata = 32'hBBB; #1;
    chk("rr2_resp", {30'd0, i_resp, d_resp}, 32'b01);
    chk("rr2_rdata", d_rdata, 32'hBBB);
    tick();
    mem_resp = 0; #1;
    tick();
    chk("rr3_addr", mem_addr, 32'h60);
    chk("rr3_strobe", {31'd0, mem_read}, 32'd1);
    mem_resp = 1; #1;
    tick();
    mem_resp = 0; i_read = 0; d_read = 0;
    tick();

    // Store path with mid-transaction input change
    d_write = 1; d_addr = 32'h104; d_wdata = 32'h0000AB00; d_wmask = 4'b0010;
    tick();
    chk("st_type", {30'd0, mem_read, mem_write}, 32'b01);
    chk("st_addr", mem_addr, 32'h104);
    chk("st_wdata", mem_wdata, 32'h0000AB00);
    chk("st_wmask", {28'd0, mem_wmask}, 32'h2);
    d_wdata = 32'hFFFFFFFF; d_wmask = 4'hF; d_addr = 32'h999;
    tick();
    chk("st_hold_wdata", mem_wdata, 32'h0000AB00);
    chk("st_hold_addr", mem_addr, 32'h104);

    // Reset during D_BUSY, then a late response
    rst = 0; #1;
    chk("rst_mid_strobe", {30'd0, mem_read, mem_write}, 32'd0);
    tick();
    rst = 1; d_write = 0; mem_resp = 1; #1;
    chk("rst_mid_no_resp", {30'd0, i_resp, d_resp}, 32'd0);

    // Spurious response while IDLE
    tick();
    chk("spur_resp", {30'd0, i_resp, d_resp}, 32'd0);
    chk("spur_idle", {30'd0, mem_read, mem_write}, 32'd0);
    mem_resp = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
